// File: rtl/line_follow_ctrl_if.sv
// Command/sensor inputs and motor/status outputs of the line follower.
// The controller is the slave; whoever drives sens/en is the master.
interface line_follow_ctrl_if #(
  parameter int NSENS  = 5,
  parameter int DUTY_W = 14,
  parameter int CNT_W  = 3
);
  logic              en;
  logic              rev_req;
  logic [CNT_W-1:0]  target;
  logic [NSENS-1:0]  sens;
  logic [DUTY_W-1:0] duty_l;
  logic [DUTY_W-1:0] duty_r;
  logic              in1;
  logic              in2;
  logic              in3;
  logic              in4;
  logic [CNT_W-1:0]  count;
  logic              done;
  logic              lost;
  logic [2:0]        state;

  modport master (
    output en, rev_req, target, sens,
    input  duty_l, duty_r,
    input  in1, in2, in3, in4,
    input  count, done, lost, state
  );

  modport slave (
    input  en, rev_req, target, sens,
    output duty_l, duty_r,
    output in1, in2, in3, in4,
    output count, done, lost, state
  );
endinterface

// File: rtl/line_follow_ctrl.sv
// Line-following robot controller: steering, debounced intersection
// counting, lost-line search and 180-degree turn, all outputs registered.
module line_follow_ctrl #(
  parameter int NSENS   = 5,
  parameter int DUTY_W  = 14,
  parameter int CNT_W   = 3,
  parameter int DEB_CYC = 16,
  parameter int BASE    = 'h1400,
  parameter int STEP    = 'h0400,
  parameter int LOST_TO = 1024
) (
  input  logic              clk,
  input  logic              rst,
  line_follow_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FOLLOW  = 3'd1;
  localparam logic [2:0] S_CROSS   = 3'd2;
  localparam logic [2:0] S_SEARCH  = 3'd3;
  localparam logic [2:0] S_REVERSE = 3'd4;
  localparam logic [2:0] S_STOP    = 3'd5;

  localparam int MID  = NSENS / 2;
  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int TW   = (LOST_TO > 2) ? $clog2(LOST_TO) : 1;
  localparam int DMAX = (1 << DUTY_W) - 1;

  localparam logic [DW-1:0] DEB  = DW'(DEB_CYC);
  localparam logic [TW-1:0] TLIM = TW'(LOST_TO - 1);

  function automatic int pop(
    input logic [NSENS-1:0] v,
    input int               lo,
    input int               hi
  );
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [DUTY_W-1:0] sat(input int v);
    if (v < 0) return '0;
    if (v > DMAX) return DUTY_W'(DMAX);
    return DUTY_W'(v);
  endfunction

  logic [NSENS-1:0]  s_q;
  logic [2:0]        st;
  logic [2:0]        st_n;
  logic [DW-1:0]     one_cnt;
  logic [DW-1:0]     one_n;
  logic [DW-1:0]     nz_cnt;
  logic [DW-1:0]     nz_n;
  logic [TW-1:0]     tmr;
  logic [TW-1:0]     tmr_n;
  logic              last_dir;
  logic              last_n;
  logic              rev_ph;
  logic              rev_ph_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              done_n;
  logic              lost_n;
  logic [DUTY_W-1:0] dl_n;
  logic [DUTY_W-1:0] dr_n;
  logic [3:0]        dir_n;
  logic              all1;
  logic              any1;
  int                err;

  assign all1      = &s_q;
  assign any1      = |s_q;
  assign bus.state = st;

  always_comb begin
    err = pop(s_q, MID + 1, NSENS - 1) - pop(s_q, 0, MID - 1);
  end

  // Run-length counters saturate so a long run keeps reporting "reached".
  always_comb begin
    one_n = '0;
    nz_n  = '0;
    if (all1) begin
      one_n = (one_cnt == DEB) ? DEB : one_cnt + DW'(1);
    end else begin
      nz_n = (nz_cnt == DEB) ? DEB : nz_cnt + DW'(1);
    end
  end

  always_comb begin
    st_n     = st;
    cnt_n    = bus.count;
    done_n   = bus.done;
    lost_n   = bus.lost;
    tmr_n    = tmr;
    last_n   = last_dir;
    rev_ph_n = rev_ph;
    if (st == S_FOLLOW && err != 0) last_n = (err > 0);
    if (!bus.en) begin
      st_n = S_IDLE;
    end else begin
      unique case (st)
        S_IDLE: begin
          st_n   = S_FOLLOW;
          cnt_n  = '0;
          done_n = 1'b0;
          lost_n = 1'b0;
        end
        S_FOLLOW: begin
          if (one_n == DEB) begin
            cnt_n = bus.count + 1'b1;
            if (bus.target != '0 &&
                cnt_n == bus.target) begin
              st_n   = S_STOP;
              done_n = 1'b1;
            end else begin
              st_n = S_CROSS;
            end
          end else if (bus.rev_req) begin
            st_n     = S_REVERSE;
            rev_ph_n = 1'b0;
          end else if (!any1) begin
            st_n  = S_SEARCH;
            tmr_n = '0;
          end
        end
        S_CROSS: begin
          if (nz_n == DEB) st_n = S_FOLLOW;
        end
        S_SEARCH: begin
          if (any1) begin
            st_n = S_FOLLOW;
          end else if (tmr == TLIM) begin
            st_n   = S_STOP;
            lost_n = 1'b1;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
        S_REVERSE: begin
          // First leave the line with the centre sensor, then reacquire it.
          if (!rev_ph) begin
            if (!s_q[MID]) rev_ph_n = 1'b1;
          end else if (s_q[MID]) begin
            st_n = S_FOLLOW;
          end
        end
        S_STOP: begin
          st_n = S_STOP;
        end
        default: begin
          st_n = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dl_n  = '0;
    dr_n  = '0;
    dir_n = 4'b0000;
    unique case (st_n)
      S_FOLLOW: begin
        dl_n  = sat(BASE - err * STEP);
        dr_n  = sat(BASE + err * STEP);
        dir_n = 4'b0110;
      end
      S_CROSS: begin
        dl_n  = sat(BASE);
        dr_n  = sat(BASE);
        dir_n = 4'b0110;
      end
      S_SEARCH: begin
        dl_n  = sat(BASE);
        dr_n  = sat(BASE);
        dir_n = last_n ? 4'b0101 : 4'b1010;
      end
      S_REVERSE: begin
        dl_n  = sat(BASE);
        dr_n  = sat(BASE);
        dir_n = 4'b1010;
      end
      default: begin
        dl_n  = '0;
        dr_n  = '0;
        dir_n = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= '0;
      st         <= S_IDLE;
      one_cnt    <= '0;
      nz_cnt     <= '0;
      tmr        <= '0;
      last_dir   <= 1'b0;
      rev_ph     <= 1'b0;
      bus.count  <= '0;
      bus.done   <= 1'b0;
      bus.lost   <= 1'b0;
      bus.duty_l <= '0;
      bus.duty_r <= '0;
      bus.in1    <= 1'b0;
      bus.in2    <= 1'b0;
      bus.in3    <= 1'b0;
      bus.in4    <= 1'b0;
    end else begin
      s_q        <= bus.sens;
      st         <= st_n;
      one_cnt    <= one_n;
      nz_cnt     <= nz_n;
      tmr        <= tmr_n;
      last_dir   <= last_n;
      rev_ph     <= rev_ph_n;
      bus.count  <= cnt_n;
      bus.done   <= done_n;
      bus.lost   <= lost_n;
      bus.duty_l <= dl_n;
      bus.duty_r <= dr_n;
      bus.in1    <= dir_n[3];
      bus.in2    <= dir_n[2];
      bus.in3    <= dir_n[1];
      bus.in4    <= dir_n[0];
    end
  end
endmodule

// File: tb/tb_line_follow_ctrl.sv
// Self-checking bench for line_follow_ctrl: directed scenarios plus
// randomized sensor traffic compared against a behavioural model.
module tb_line_follow_ctrl;
  localparam int NS   = 5;
  localparam int DUW  = 14;
  localparam int CW   = 3;
  localparam int DEB  = 4;
  localparam int BASE = 'h1400;
  localparam int STP  = 'h0400;
  localparam int LOST = 16;
  localparam int C    = NS / 2;

  localparam int IDLE    = 0;
  localparam int FOLLOW  = 1;
  localparam int CROSS   = 2;
  localparam int SEARCH  = 3;
  localparam int REVERSE = 4;
  localparam int STOP    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  line_follow_ctrl_if #(
    .NSENS(NS), .DUTY_W(DUW), .CNT_W(CW)
  ) bus ();

  line_follow_ctrl #(
    .NSENS(NS), .DUTY_W(DUW), .CNT_W(CW),
    .DEB_CYC(DEB), .BASE(BASE), .STEP(STP),
    .LOST_TO(LOST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model state: mode, registered sensors, run lengths, timers
  int          m_mode;
  logic [NS-1:0] m_sq;
  int          m_ones;
  int          m_other;
  int          m_tmr;
  bit          m_dir;
  bit          m_gap;
  int          m_cnt;
  bit          m_done;
  bit          m_lost;
  int          m_dl;
  int          m_dr;
  logic [3:0]  m_in;

  function automatic int ones_in(
    input logic [NS-1:0] v, input int lo, input int hi
  );
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > (1 << DUW) - 1) return (1 << DUW) - 1;
    return v;
  endfunction

  function automatic logic [39:0] dut_vec();
    return {bus.state, bus.duty_l, bus.duty_r,
            bus.in1, bus.in2, bus.in3, bus.in4,
            bus.count, bus.done, bus.lost};
  endfunction

  function automatic logic [39:0] model_vec();
    return {3'(m_mode), 14'(m_dl), 14'(m_dr), m_in,
            3'(m_cnt), m_done, m_lost};
  endfunction

  task automatic model_reset();
    m_mode  = IDLE;
    m_sq    = '0;
    m_ones  = 0;
    m_other = 0;
    m_tmr   = 0;
    m_dir   = 0;
    m_gap   = 0;
    m_cnt   = 0;
    m_done  = 0;
    m_lost  = 0;
    m_dl    = 0;
    m_dr    = 0;
    m_in    = 4'b0000;
  endtask

  // One clock of the behavioural model, using inputs present at the edge.
  task automatic model_step();
    int e;
    bit all1;
    bit none;
    all1 = (m_sq == '1);
    none = (m_sq == '0);
    e = ones_in(m_sq, C + 1, NS - 1) - ones_in(m_sq, 0, C - 1);
    if (all1) begin
      m_ones++;
      m_other = 0;
    end else begin
      m_ones = 0;
      m_other++;
    end
    if (m_mode == FOLLOW && e != 0) m_dir = (e > 0);
    if (!bus.en) m_mode = IDLE;
    else case (m_mode)
      IDLE: begin
        m_mode = FOLLOW;
        m_cnt  = 0;
        m_done = 0;
        m_lost = 0;
      end
      FOLLOW: begin
        if (m_ones >= DEB) begin
          m_cnt = (m_cnt + 1) % (1 << CW);
          if (bus.target != 0 && m_cnt == int'(bus.target)) begin
            m_mode = STOP;
            m_done = 1;
          end else m_mode = CROSS;
        end else if (bus.rev_req) begin
          m_mode = REVERSE;
          m_gap  = 0;
        end else if (none) begin
          m_mode = SEARCH;
          m_tmr  = 0;
        end
      end
      CROSS: if (m_other >= DEB) m_mode = FOLLOW;
      SEARCH: begin
        if (!none) m_mode = FOLLOW;
        else if (m_tmr == LOST - 1) begin
          m_mode = STOP;
          m_lost = 1;
        end else m_tmr++;
      end
      REVERSE: begin
        if (!m_gap) m_gap = !m_sq[C];
        else if (m_sq[C]) m_mode = FOLLOW;
      end
      default: ;
    endcase
    case (m_mode)
      FOLLOW: begin
        m_dl = clamp(BASE - e * STP);
        m_dr = clamp(BASE + e * STP);
        m_in = 4'b0110;
      end
      CROSS: begin
        m_dl = BASE; m_dr = BASE; m_in = 4'b0110;
      end
      SEARCH: begin
        m_dl = BASE; m_dr = BASE;
        m_in = m_dir ? 4'b0101 : 4'b1010;
      end
      REVERSE: begin
        m_dl = BASE; m_dr = BASE; m_in = 4'b1010;
      end
      default: begin
        m_dl = 0; m_dr = 0; m_in = 4'b0000;
      end
    endcase
    m_sq = bus.sens;
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic restart(input logic [NS-1:0] s);
    bus.en   = 1'b0;
    bus.sens = s;
    step(1);
    bus.en = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    bus.en      = 1'b0;
    bus.rev_req = 1'b0;
    bus.target  = 3'd2;
    bus.sens    = '0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if (dut_vec() !== 40'h0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want %h", dut_vec(), 40'h0);
    end
    #4 rst = 1'b0;
    step(2);
    n_chk++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL idle_after_reset got %h want %h",
               dut_vec(), model_vec());
    end
  endtask

  task automatic test_follow();
    bus.sens = 5'b00100;
    step(1);
    bus.en = 1'b1;
    step(2);
    n_chk++;
    if ({bus.state, bus.duty_l, bus.duty_r,
         bus.in1, bus.in2, bus.in3, bus.in4} !==
        {3'd1, 14'h1400, 14'h1400, 4'b0110}) begin
      n_err++;
      $display("FAIL follow_centre got %h want state1 1400/1400 0110",
               dut_vec());
    end
    n_chk++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL follow_model got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_steer();
    bus.sens = 5'b11000;
    step(2);
    n_chk++;
    if ({bus.duty_l, bus.duty_r} !== {14'h0C00, 14'h1C00}) begin
      n_err++;
      $display("FAIL steer_left got %h/%h want 0c00/1c00",
               bus.duty_l, bus.duty_r);
    end
    bus.sens = 5'b00011;
    step(2);
    n_chk++;
    if ({bus.duty_l, bus.duty_r} !== {14'h1C00, 14'h0C00}) begin
      n_err++;
      $display("FAIL steer_right got %h/%h want 1c00/0c00",
               bus.duty_l, bus.duty_r);
    end
    bus.sens = 5'b11000;
    step(2);
  endtask

  task automatic test_cross();
    bus.sens = 5'b11111;
    step(3);
    bus.sens = 5'b00100;
    step(3);
    n_chk++;
    if ({bus.state, bus.count} !== {3'd1, 3'd0}) begin
      n_err++;
      $display("FAIL short_cross got state %0d count %0d want 1/0",
               bus.state, bus.count);
    end
    bus.sens = 5'b11111;
    step(5);
    n_chk++;
    if ({bus.state, bus.count} !== {3'd2, 3'd1}) begin
      n_err++;
      $display("FAIL cross_one got state %0d count %0d want 2/1",
               bus.state, bus.count);
    end
    step(3);
    n_chk++;
    if (bus.count !== 3'd1) begin
      n_err++;
      $display("FAIL cross_no_recount got %0d want 1", bus.count);
    end
    bus.sens = 5'b00100;
    step(6);
    n_chk++;
    if (bus.state !== 3'd1) begin
      n_err++;
      $display("FAIL cross_exit got %0d want 1", bus.state);
    end
    bus.sens = 5'b11111;
    step(6);
    n_chk++;
    if (dut_vec() !== {3'd5, 28'h0, 4'b0000, 3'd2, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL target_stop got %h want state5 count2 done",
               dut_vec());
    end
    n_chk++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL cross_model got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_search();
    bus.en   = 1'b0;
    bus.sens = 5'b11000;
    step(1);
    n_chk++;
    if ({bus.state, bus.count, bus.done} !== {3'd0, 3'd2, 1'b1}) begin
      n_err++;
      $display("FAIL idle_hold got state %0d count %0d done %0d",
               bus.state, bus.count, bus.done);
    end
    bus.en = 1'b1;
    step(3);
    bus.sens = 5'b00000;
    step(3);
    n_chk++;
    if ({bus.state, bus.in1, bus.in2, bus.in3, bus.in4} !==
        {3'd3, 4'b0101}) begin
      n_err++;
      $display("FAIL search_left got %h want state3 0101", dut_vec());
    end
    step(20);
    n_chk++;
    if ({bus.state, bus.lost, bus.duty_l} !== {3'd5, 1'b1, 14'h0}) begin
      n_err++;
      $display("FAIL search_lost got state %0d lost %0d want 5/1",
               bus.state, bus.lost);
    end
    n_chk++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL search_model got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reverse();
    restart(5'b00100);
    bus.rev_req = 1'b1;
    step(1);
    bus.rev_req = 1'b0;
    step(1);
    n_chk++;
    if ({bus.state, bus.in1, bus.in2, bus.in3, bus.in4} !==
        {3'd4, 4'b1010}) begin
      n_err++;
      $display("FAIL reverse_pivot got %h want state4 1010", dut_vec());
    end
    step(2);
    n_chk++;
    if (bus.state !== 3'd4) begin
      n_err++;
      $display("FAIL reverse_wait got %0d want 4", bus.state);
    end
    bus.sens = 5'b01000;
    step(2);
    bus.sens = 5'b00100;
    step(2);
    n_chk++;
    if (bus.state !== 3'd1) begin
      n_err++;
      $display("FAIL reverse_done got %0d want 1", bus.state);
    end
    n_chk++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL reverse_model got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reset_mid_cross();
    bus.target = 3'd2;
    restart(5'b00100);
    bus.sens = 5'b11111;
    step(6);
    n_chk++;
    if ({bus.state, bus.count} !== {3'd2, 3'd1}) begin
      n_err++;
      $display("FAIL pre_reset got state %0d count %0d want 2/1",
               bus.state, bus.count);
    end
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (dut_vec() !== 40'h0) begin
      n_err++;
      $display("FAIL async_reset got %h want %h", dut_vec(), 40'h0);
    end
    model_reset();
    rst    = 1'b0;
    bus.en = 1'b1;
    step(3);
    n_chk++;
    if ({bus.state, bus.count} !== {3'd1, 3'd0}) begin
      n_err++;
      $display("FAIL reset_discard got state %0d count %0d want 1/0",
               bus.state, bus.count);
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] pat [9];
    int hold;
    int k;
    pat = '{5'b00100, 5'b01100, 5'b11000, 5'b00011, 5'b00110,
            5'b10000, 5'b00001, 5'b11111, 5'b00000};
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        k = int'($urandom_range(0, 9));
        bus.sens = (k == 9) ? NS'($urandom) : pat[k];
        if (bus.sens == '0 || bus.sens == '1)
          hold = int'($urandom_range(1, 22));
        else
          hold = int'($urandom_range(1, 8));
      end
      hold--;
      bus.en      = ($urandom_range(0, 79) != 0);
      bus.rev_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 99) == 0) bus.target = CW'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
      end
      step(1);
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL random_cycle%0d got %h want %h",
                 c, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_follow();
    test_steer();
    test_cross();
    test_search();
    test_reverse();
    test_reset_mid_cross();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
